fadd_align: RTL and testbench

FADD_ALIGN -- requirements
Module: fadd_align

---
 rtl/fadd_align.sv | 90 +++++++++
 tb/tb_fadd_align.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fadd_align.sv
// fadd_align: FP32 add/sub front end (unpack, swap, align with sticky, add/sub) before normalization.
// Define FADD_ALIGN_FAST_EN for a single-cycle barrel-shift align instead of the serial shifter.
module fadd_align (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [7:0]  temp_exp,
    output logic [27:0] cal_frac
);
    typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;
    state_t state, state_nxt;
    logic [26:0] mx, my, my_nxt, ma, mb;
    logic [7:0]  ex, ea, eb, diff;
    logic [4:0]  cnt, n;
    logic        sx, sy, swap, eff_sub, last;
    logic [27:0] res;
    assign ea = |a[30:23] ? a[30:23] : 8'd1;
    assign eb = |b[30:23] ? b[30:23] : 8'd1;
    assign ma = {|a[30:23], a[22:0], 3'b000};
    assign mb = {|b[30:23], b[22:0], 3'b000};
    assign swap = b[30:0] > a[30:0];
    assign diff = swap ? eb - ea : ea - eb;
    assign n = diff > 8'd27 ? 5'd27 : diff[4:0];
`ifdef FADD_ALIGN_FAST_EN
    logic [26:0] mask;
    assign mask = (27'd1 << cnt) - 27'd1;
    assign my_nxt = (my >> cnt) | {26'd0, |(my & mask)};
    assign last = 1'b1;
`else
    // shifted-out bits accumulate into bit 0 as sticky
    assign my_nxt = cnt != 5'd0 ? {1'b0, my[26:1]} | {26'd0, my[0]} : my;
    assign last = cnt <= 5'd1;
`endif
    assign eff_sub = sx ^ sy;
    assign res = eff_sub ? {1'b0, mx} - {1'b0, my} : {1'b0, mx} + {1'b0, my};
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = in_valid ? ALIGN : IDLE;
            ALIGN: state_nxt = last ? ADD : ALIGN;
            ADD:   state_nxt = DONE;
            DONE:  state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mx <= '0;
            my <= '0;
            ex <= '0;
            sx <= 1'b0;
            sy <= 1'b0;
            cnt <= '0;
            sign <= 1'b0;
            temp_exp <= '0;
            cal_frac <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                mx <= swap ? mb : ma;
                my <= swap ? ma : mb;
                ex <= swap ? eb : ea;
                sx <= swap ? b[31] ^ sub : a[31];
                sy <= swap ? a[31] : b[31] ^ sub;
                cnt <= n;
            end else if (state == ALIGN) begin
                my <= my_nxt;
`ifdef FADD_ALIGN_FAST_EN
                cnt <= 5'd0;
`else
                cnt <= cnt != 5'd0 ? cnt - 5'd1 : 5'd0;
`endif
            end else if (state == ADD) begin
                cal_frac <= res;
                temp_exp <= ex;
                sign <= (eff_sub && res == 28'd0) ? 1'b0 : sx;
            end
        end
    end
endmodule

// File: tb/tb_fadd_align.sv
// tb_fadd_align: vector table plus scoreboard bench for fadd_align, including hold and reset-abort sequences.
module tb_fadd_align;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, sub;
    logic [31:0] a, b;
    logic        in_ready, out_valid, sign;
    logic [7:0]  temp_exp;
    logic [27:0] cal_frac;

    fadd_align dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .temp_exp(temp_exp), .cal_frac(cal_frac)
    );

    always #5 clk = ~clk;

`ifdef FADD_ALIGN_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [31:0] a, b;
        logic        sub, sign;
        logic [7:0]  te;
        logic [27:0] cf;
        int          lat_s;
    } vec_t;
    typedef struct {
        logic        sign;
        logic [7:0]  te;
        logic [27:0] cf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[8];
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start(input vec_t v);
        exp_t e;
        @(negedge clk);
        chk("in_ready_before_op", in_ready, 1);
        a = v.a;
        b = v.b;
        sub = v.sub;
        in_valid = 1'b1;
        @(posedge clk);
        e.sign = v.sign;
        e.te = v.te;
        e.cf = v.cf;
        e.lat = FAST ? 2 : v.lat_s;
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic compare(input int lat, input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d latency", idx), lat, e.lat);
        chk($sformatf("v%0d sign", idx), sign, e.sign);
        chk($sformatf("v%0d temp_exp", idx), temp_exp, e.te);
        chk($sformatf("v%0d cal_frac", idx), cal_frac, e.cf);
    endtask

    task automatic run_vec(input int idx);
        int lat;
        start(vt[idx]);
        wait_out(lat);
        compare(lat, idx);
        @(posedge clk);
        #1 chk($sformatf("v%0d in_ready_after", idx), in_ready, 1);
        chk($sformatf("v%0d out_valid_after", idx), out_valid, 0);
    endtask

    initial begin
        int lat;
        logic [27:0] cf_hold;
        logic [7:0]  te_hold;
        logic        s_hold;
        vt[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 8'h7F, 28'h8000000, 2};
        vt[1] = '{32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 8'h7F, 28'h0000000, 2};
        vt[2] = '{32'h3E800000, 32'h3FC00000, 1'b1, 1'b1, 8'h7F, 28'h5000000, 3};
        vt[3] = '{32'h3F800000, 32'h2B800000, 1'b0, 1'b0, 8'h7F, 28'h4000001, 28};
        vt[4] = '{32'h3F800000, 32'h33000000, 1'b0, 1'b0, 8'h7F, 28'h4000002, 26};
        vt[5] = '{32'h40000000, 32'h3F800000, 1'b0, 1'b0, 8'h80, 28'h6000000, 2};
        vt[6] = '{32'hC0000000, 32'h40000000, 1'b1, 1'b1, 8'h80, 28'h8000000, 2};
        vt[7] = '{32'h00000001, 32'h00000001, 1'b0, 1'b0, 8'h01, 28'h0000010, 2};
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sub = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset cal_frac", cal_frac, 0);
        chk("reset temp_exp", temp_exp, 0);
        chk("reset sign", sign, 0);
        @(negedge clk) rst = 1'b0;
        #1 chk("reset in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(i);

        // hold result while downstream stalls, with a competing request pending
        out_ready = 1'b0;
        start(vt[2]);
        wait_out(lat);
        compare(lat, 20);
        cf_hold = cal_frac;
        te_hold = temp_exp;
        s_hold = sign;
        a = 32'h40400000;
        b = 32'h3F800000;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("hold out_valid", out_valid, 1);
            chk("hold in_ready", in_ready, 0);
            chk("hold cal_frac", cal_frac, cf_hold);
            chk("hold temp_exp", temp_exp, te_hold);
            chk("hold sign", sign, s_hold);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("release in_ready", in_ready, 1);
        chk("release out_valid", out_valid, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("no_capture in_ready", in_ready, 1);

        // reset in the middle of the long alignment
        start(vt[3]);
        if (!FAST) repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("abort out_valid", out_valid, 0);
        chk("abort cal_frac", cal_frac, 0);
        sb.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("abort in_ready", in_ready, 1);
        chk("abort no_output", out_valid, 0);
        run_vec(3);
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
